load_store_unit: RTL and testbench

- Consumes the effective address computed by the ALU for RISC-V MEM-class instructions (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Performs the data-memory transaction over a valid/ready word bus: byte-lane steering and byte enables for stores, lane extraction and sign/zero extension for loads.
- Sits between execute and writeback. Multi-cycle; the core stalls on `busy`.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/lsu_lane.sv | 84 ++++++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V definitions for the memory pipeline: funct3 access encodings,
// MEM opcode fields and the load/store FSM state type.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // opcode[6:2] of MEM-class instructions is 0?000; bit 5 selects store.
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_MEM_MASK = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_e;

    function automatic logic is_mem_opcode(input logic [6:0] opcode);
        return (opcode[1:0] == 2'b11) && ((opcode[6:2] & OPC_MEM_MASK) == OPC_LOAD);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: legality/alignment checks, store steering
// and byte enables, load lane extraction with sign/zero extension.
module lsu_lane
    import rv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        illegal = 1'b1;
        if (is_store) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: illegal = 1'b0;
                default:             illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
                default:                             illegal = 1'b1;
            endcase
        end

        // An illegal encoding has no meaningful size, so it never reports misalignment.
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
        if (illegal) misaligned = 1'b0;
    end

    always_comb begin
        be    = '1;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = '1;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {24'b0, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {16'b0, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one MEM-class access over a valid/ready word bus,
// reporting illegal/misaligned requests without touching memory.
module load_store_unit
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              illegal,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e  state, state_n;

    logic        req_store;
    logic [2:0]  req_f3;
    logic [1:0]  req_off;

    logic        ln_store;
    logic [2:0]  ln_f3;
    logic [1:0]  ln_off;
    logic [3:0]  ln_be;
    logic [31:0] ln_wdata;
    logic [31:0] ln_load;
    logic        ln_misaligned;
    logic        ln_illegal;
    logic        ln_fault;

    // One lane instance serves both phases: live inputs while idle (checks and
    // steering), latched request afterwards (load extraction from mem_rdata).
    always_comb begin
        if (state == ST_IDLE) begin
            ln_store = is_store;
            ln_f3    = funct3;
            ln_off   = addr[1:0];
        end else begin
            ln_store = req_store;
            ln_f3    = req_f3;
            ln_off   = req_off;
        end
    end

    lsu_lane u_lane (
        .is_store   (ln_store),
        .funct3     (ln_f3),
        .offset     (ln_off),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (ln_be),
        .wdata      (ln_wdata),
        .load_data  (ln_load),
        .misaligned (ln_misaligned),
        .illegal    (ln_illegal)
    );

    assign ln_fault = ln_illegal | ln_misaligned;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ln_fault ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_ready) state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_RESP);
    assign mem_valid = (state == ST_REQ);
    assign mem_we    = (state == ST_REQ) && req_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_store  <= 1'b0;
            req_f3     <= '0;
            req_off    <= '0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            load_data  <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_store  <= is_store;
                        req_f3     <= funct3;
                        req_off    <= addr[1:0];
                        mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be     <= is_store ? ln_be : 4'b1111;
                        mem_wdata  <= is_store ? ln_wdata : '0;
                        misaligned <= ln_misaligned;
                        illegal    <= ln_illegal;
                        if (ln_fault) load_data <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) load_data <= req_store ? '0 : ln_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// transactions compared against an arithmetic model of the access rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ld = '0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of one access, then drive it and check every cycle.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int delay, input logic poke);
        logic        legal, mis;
        int          n, o, be_i;
        logic [31:0] mask, v, e_wdata;
        logic [3:0]  e_be;

        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f3[1:0];
        o     = int'(a[1:0]);
        mis   = legal && ((o % n) != 0);
        be_i  = ((1 << n) - 1) << o;
        e_be  = st ? be_i[3:0] : 4'hF;
        if (n == 1)      e_wdata = {24'b0, sd[7:0]} * 32'h0101_0101;
        else if (n == 2) e_wdata = {16'b0, sd[15:0]} * 32'h0001_0001;
        else             e_wdata = sd;
        if (n == 4) v = rd;
        else begin
            mask = (n == 1) ? 32'hFF : 32'hFFFF;
            v    = (rd >> (8 * o)) & mask;
            if (!f3[2] && ((v & ((mask + 1) >> 1)) != 0)) v = v | ~mask;
        end

        is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);

        if (!legal || mis) begin
            exp_ld = '0;
            chk("fault_done", done, 1'b1);
            chk("fault_mem_valid", mem_valid, 1'b0);
            chk("fault_illegal", illegal, !legal);
            chk("fault_misaligned", misaligned, mis);
            chk("fault_load_data", load_data, exp_ld);
            step();
            chk("fault_done_clear", done, 1'b0);
            chk("fault_busy_clear", busy, 1'b0);
            chk("fault_no_access", mem_valid, 1'b0);
            return;
        end

        for (int i = 0; i <= delay; i++) begin
            chk("req_valid", mem_valid, 1'b1);
            chk("req_we", mem_we, st);
            chk("req_addr", mem_addr, {a[31:2], 2'b00});
            chk("req_be", mem_be, e_be);
            if (st) chk("req_wdata", mem_wdata, e_wdata);
            chk("req_no_done", done, 1'b0);
            chk("req_busy", busy, 1'b1);
            if (i < delay) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                if (poke && i == 0) begin
                    start = 1'b1; is_store = ~st; addr = $urandom; funct3 = 3'd2;
                end
            end else begin
                start = 1'b0;
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        exp_ld = st ? 32'h0 : v;
        chk("resp_done", done, 1'b1);
        chk("resp_valid_drop", mem_valid, 1'b0);
        chk("resp_busy", busy, 1'b1);
        chk("resp_illegal", illegal, 1'b0);
        chk("resp_misaligned", misaligned, 1'b0);
        chk("resp_load_data", load_data, exp_ld);
        step();
        chk("post_done_clear", done, 1'b0);
        chk("post_busy_clear", busy, 1'b0);
        chk("post_load_hold", load_data, exp_ld);
    endtask

    initial begin
        logic        r_st;
        logic [2:0]  r_f3;
        logic [31:0] r_a;

        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_flags", {misaligned, illegal}, 2'b00);
        rst = 1'b0;
        step();

        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        chk("lw_value", load_data, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 1'b0);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 1, 1'b0);
        chk("lbu_value", load_data, 32'h0000_0080);
        run_txn(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b1, 3'b000, 32'h41, 32'h0000_00A5, 32'h0, 5, 1'b1);

        // Reset while a request is outstanding.
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; start = 1'b1;
        step();
        start = 1'b0;
        chk("rstmid_valid", mem_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ld = '0;
        chk("rstmid_valid_drop", mem_valid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        step();
        chk("rstmid_no_done", done, 1'b0);
        run_txn(1'b0, 3'b101, 32'h46, 32'h0, 32'h9ABC_1234, 2, 1'b0);

        for (int k = 0; k < 300; k++) begin
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_f3[1:0] == 2'b01) r_a[0] = 1'b0;
                if (r_f3[1:0] == 2'b10) r_a[1:0] = 2'b00;
            end
            run_txn(r_st, r_f3, r_a, $urandom, $urandom, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
